// File: rtl/ts_slot_scheduler.sv
// rtl/ts_slot_scheduler.sv - PSI/SI table vs T2-MI slot source scheduler
//
// Decides, for every 188-byte output slot, whether the packet comes from the
// T2-MI buffer, one of the periodic tables (PAT, PMT, SDT) or a null packet.
// Each table has a repetition timer advanced by the 1 ms TICK; an expiring
// timer raises the table's pending flag, and the slot FSM grants pending
// tables ahead of T2-MI traffic, interleaving one T2-MI packet after each
// table slot whenever T2-MI data is waiting.
//
// Build option: TS_NULL_PKT_EN - when defined, a slot with no candidate is
// filled with a null packet (SEL=4); when undefined the FSM waits in DECIDE
// until a candidate appears.
//
// Parameters:
//   PERIOD_W    width of the period inputs and the table timers (TICK units)
// Ports:
//   CLK         system clock, rising edge
//   RST         asynchronous active-low reset
//   TICK        one-cycle 1 ms timebase pulse
//   PERIOD_PAT  PAT repetition period in ticks, 0 disables the table
//   PERIOD_PMT  PMT repetition period in ticks, 0 disables the table
//   PERIOD_SDT  SDT repetition period in ticks, 0 disables the table
//   T2MI_READY  a complete T2-MI packet is buffered
//   SLOT_REQ    level, packet output wants a source for the next slot
//   PKT_DONE    one-cycle pulse, selected source finished its packet
//   SEL         slot source: 0 T2MI, 1 PAT, 2 PMT, 3 SDT, 4 NULL
//   SEL_VALID   one-cycle pulse qualifying a new SEL
//   OVERRUN     sticky {SDT,PMT,PAT} flags, table expired while still pending
//   STATE_MON   current FSM state (0 IDLE, 1 DECIDE, 2 BUSY)

module ts_slot_scheduler #(
    parameter int PERIOD_W = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                TICK,
    input  logic [PERIOD_W-1:0] PERIOD_PAT,
    input  logic [PERIOD_W-1:0] PERIOD_PMT,
    input  logic [PERIOD_W-1:0] PERIOD_SDT,
    input  logic                T2MI_READY,
    input  logic                SLOT_REQ,
    input  logic                PKT_DONE,
    output logic [2:0]          SEL,
    output logic                SEL_VALID,
    output logic [2:0]          OVERRUN,
    output logic [1:0]          STATE_MON
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECIDE = 2'd1,
        BUSY   = 2'd2
    } state_t;

    localparam logic [2:0] SEL_T2MI = 3'd0;
    localparam logic [2:0] SEL_PAT  = 3'd1;
    localparam logic [2:0] SEL_PMT  = 3'd2;
    localparam logic [2:0] SEL_SDT  = 3'd3;
    localparam logic [2:0] SEL_NULL = 3'd4;

    // Table index i corresponds to SEL value i+1 and OVERRUN bit i.
    localparam int NTAB = 3;

    state_t              state;
    state_t              state_next;

    logic [PERIOD_W-1:0] period    [NTAB];
    logic [PERIOD_W-1:0] timer     [NTAB];
    // One bit wider than the timer so timer+1 cannot wrap past the period.
    logic [PERIOD_W:0]   timer_inc [NTAB];

    logic [NTAB-1:0]     expire;
    logic [NTAB-1:0]     pending;
    logic [NTAB-1:0]     grant_clr;
    logic [NTAB-1:0]     overrun;

    logic                prev_table;
    logic                cand_valid;
    logic [2:0]          cand_sel;
    logic                grant;
    logic [2:0]          grant_sel;

    logic [2:0]          sel_q;
    logic                sel_valid_q;

    assign period[0] = PERIOD_PAT;
    assign period[1] = PERIOD_PMT;
    assign period[2] = PERIOD_SDT;

    // ------------------------------------------------------------------
    // Table timers: run in every FSM state, held at 0 while disabled.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NTAB; i++) begin
            timer_inc[i] = {1'b0, timer[i]} + {{PERIOD_W{1'b0}}, 1'b1};
            expire[i]    = TICK && (period[i] != '0)
                           && (timer_inc[i] >= {1'b0, period[i]});
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < NTAB; i++) begin
                timer[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NTAB; i++) begin
                if (period[i] == '0) begin
                    timer[i] <= '0;
                end else if (TICK) begin
                    timer[i] <= expire[i] ? '0 : timer_inc[i][PERIOD_W-1:0];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending and overrun flags. An expiry in the same cycle as the grant
    // that clears the flag wins: the new instance stays pending, and since
    // the old instance was just served it is not an overrun.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NTAB; i++) begin
            grant_clr[i] = grant && (grant_sel == 3'(i + 1));
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pending <= '0;
            overrun <= '0;
        end else begin
            pending <= expire | (pending & ~grant_clr);
            overrun <= overrun | (expire & pending & ~grant_clr);
        end
    end

    // ------------------------------------------------------------------
    // Candidate selection: tables in PAT > PMT > SDT order, then T2-MI.
    // A waiting T2-MI packet jumps ahead once after every table slot so a
    // burst of tables cannot starve the T2-MI stream.
    // ------------------------------------------------------------------
    always_comb begin
        cand_valid = 1'b1;
        cand_sel   = SEL_T2MI;
        if (prev_table && T2MI_READY) begin
            cand_sel = SEL_T2MI;
        end else if (pending[0]) begin
            cand_sel = SEL_PAT;
        end else if (pending[1]) begin
            cand_sel = SEL_PMT;
        end else if (pending[2]) begin
            cand_sel = SEL_SDT;
        end else if (T2MI_READY) begin
            cand_sel = SEL_T2MI;
        end else begin
            cand_valid = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Slot FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        grant_sel  = cand_sel;
        case (state)
            IDLE: begin
                if (SLOT_REQ) begin
                    state_next = DECIDE;
                end
            end
            DECIDE: begin
                if (cand_valid) begin
                    grant      = 1'b1;
                    state_next = BUSY;
                end
`ifdef TS_NULL_PKT_EN
                else begin
                    grant      = 1'b1;
                    grant_sel  = SEL_NULL;
                    state_next = BUSY;
                end
`endif
            end
            BUSY: begin
                if (PKT_DONE) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered grant outputs: SEL_VALID appears the cycle after the
    // decision, and SEL holds until the next grant.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sel_q       <= SEL_T2MI;
            sel_valid_q <= 1'b0;
            prev_table  <= 1'b0;
        end else begin
            sel_valid_q <= grant;
            if (grant) begin
                sel_q      <= grant_sel;
                prev_table <= (grant_sel != SEL_T2MI) && (grant_sel != SEL_NULL);
            end
        end
    end

    assign SEL       = sel_q;
    assign SEL_VALID = sel_valid_q;
    assign OVERRUN   = overrun;
    assign STATE_MON = state;

endmodule

// File: tb/tb_ts_slot_scheduler.sv
// tb/tb_ts_slot_scheduler.sv - self-checking bench for ts_slot_scheduler
module tb_ts_slot_scheduler;

    logic       CLK;
    logic       RST;
    logic       TICK;
    logic [7:0] PERIOD_PAT;
    logic [7:0] PERIOD_PMT;
    logic [7:0] PERIOD_SDT;
    logic       T2MI_READY;
    logic       SLOT_REQ;
    logic       PKT_DONE;
    logic [2:0] SEL;
    logic       SEL_VALID;
    logic [2:0] OVERRUN;
    logic [1:0] STATE_MON;

    int total = 0;
    int bad   = 0;
    logic [2:0] exp_q [$];

    ts_slot_scheduler #(.PERIOD_W(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .TICK       (TICK),
        .PERIOD_PAT (PERIOD_PAT),
        .PERIOD_PMT (PERIOD_PMT),
        .PERIOD_SDT (PERIOD_SDT),
        .T2MI_READY (T2MI_READY),
        .SLOT_REQ   (SLOT_REQ),
        .PKT_DONE   (PKT_DONE),
        .SEL        (SEL),
        .SEL_VALID  (SEL_VALID),
        .OVERRUN    (OVERRUN),
        .STATE_MON  (STATE_MON)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    // Scoreboard: every SEL_VALID must match the oldest expected source.
    always @(negedge CLK) begin
        if (RST && SEL_VALID) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sel_unexpected got=%0d want=none", SEL);
            end else begin
                logic [2:0] e;
                e = exp_q.pop_front();
                if (SEL !== e) begin
                    bad++;
                    $display("FAIL sel_seq got=%0d want=%0d", SEL, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            TICK = 1'b1;
            @(posedge CLK); #1;
            TICK = 1'b0;
            @(posedge CLK); #1;
        end
    endtask

    // Counts negedges until SEL_VALID; 0 means it never came.
    task automatic wait_valid(output int lat);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLK);
            if (SEL_VALID) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) begin
            total++;
            bad++;
            $display("FAIL sel_valid_timeout got=none want=pulse");
        end
    endtask

    task automatic end_slot();
        @(posedge CLK); #1;
        SLOT_REQ = 1'b0;
        PKT_DONE = 1'b1;
        @(posedge CLK); #1;
        PKT_DONE = 1'b0;
    endtask

    task automatic do_slot(input logic [2:0] want, output int lat);
        exp_q.push_back(want);
        SLOT_REQ = 1'b1;
        wait_valid(lat);
        end_slot();
    endtask

    typedef struct {
        logic [7:0] pat;
        logic [7:0] pmt;
        logic [7:0] sdt;
        logic       t2mi;
        int         ticks;
        logic [2:0] sel;
        logic [2:0] ovr;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    initial begin
        int lat;

        // periods, T2MI_READY, ticks before slot, expected SEL, expected OVERRUN
        vecs[0]  = '{8'd1, 8'd1, 8'd1, 1'b1, 1, 3'd1, 3'b000};
        vecs[1]  = '{8'd0, 8'd0, 8'd0, 1'b1, 0, 3'd0, 3'b000};
        vecs[2]  = '{8'd0, 8'd0, 8'd0, 1'b1, 0, 3'd2, 3'b000};
        vecs[3]  = '{8'd0, 8'd0, 8'd0, 1'b1, 0, 3'd0, 3'b000};
        vecs[4]  = '{8'd0, 8'd0, 8'd0, 1'b1, 0, 3'd3, 3'b000};
        vecs[5]  = '{8'd0, 8'd0, 8'd0, 1'b1, 0, 3'd0, 3'b000};
        vecs[6]  = '{8'd0, 8'd0, 8'd0, 1'b1, 0, 3'd0, 3'b000};
        vecs[7]  = '{8'd3, 8'd0, 8'd0, 1'b1, 1, 3'd0, 3'b000};
        vecs[8]  = '{8'd3, 8'd0, 8'd0, 1'b1, 1, 3'd0, 3'b000};
        vecs[9]  = '{8'd3, 8'd0, 8'd0, 1'b1, 1, 3'd1, 3'b000};
        vecs[10] = '{8'd3, 8'd0, 8'd0, 1'b1, 1, 3'd0, 3'b000};
        vecs[11] = '{8'd3, 8'd0, 8'd0, 1'b1, 1, 3'd0, 3'b000};
        vecs[12] = '{8'd3, 8'd0, 8'd0, 1'b1, 1, 3'd1, 3'b000};
        vecs[13] = '{8'd0, 8'd0, 8'd0, 1'b1, 0, 3'd0, 3'b000};
        vecs[14] = '{8'd0, 8'd1, 8'd0, 1'b0, 2, 3'd2, 3'b010};
        vecs[15] = '{8'd0, 8'd0, 8'd0, 1'b1, 0, 3'd0, 3'b010};
        vecs[16] = '{8'd0, 8'd0, 8'd2, 1'b0, 4, 3'd3, 3'b110};
        vecs[17] = '{8'd0, 8'd0, 8'd0, 1'b1, 0, 3'd0, 3'b110};
        vecs[18] = '{8'd0, 8'd1, 8'd1, 1'b1, 1, 3'd2, 3'b110};
        vecs[19] = '{8'd0, 8'd0, 8'd0, 1'b0, 0, 3'd3, 3'b110};
        vecs[20] = '{8'd0, 8'd0, 8'd0, 1'b1, 0, 3'd0, 3'b110};

        RST        = 1'b0;
        TICK       = 1'b0;
        PERIOD_PAT = '0;
        PERIOD_PMT = '0;
        PERIOD_SDT = '0;
        T2MI_READY = 1'b0;
        SLOT_REQ   = 1'b0;
        PKT_DONE   = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_sel",       SEL,       0);
        check("rst_sel_valid", SEL_VALID, 0);
        check("rst_overrun",   OVERRUN,   0);
        check("rst_state",     STATE_MON, 0);
        RST = 1'b1;
        @(posedge CLK); #1;

        // Empty slot: null packet or stall in DECIDE until T2-MI arrives.
        SLOT_REQ = 1'b1;
`ifdef TS_NULL_PKT_EN
        exp_q.push_back(3'd4);
        wait_valid(lat);
        check("null_latency", lat, 3);
`else
        repeat (10) @(negedge CLK);
        check("stall_in_decide", STATE_MON, 1);
        exp_q.push_back(3'd0);
        @(posedge CLK); #1;
        T2MI_READY = 1'b1;
        wait_valid(lat);
        check("stall_release_latency", lat, 2);
`endif
        // SLOT_REQ still high in BUSY must be ignored.
        repeat (3) @(negedge CLK);
        check("busy_hold", STATE_MON, 2);
        @(posedge CLK); #1;
        SLOT_REQ = 1'b0;
        PKT_DONE = 1'b1;
        @(posedge CLK); #1;
        PKT_DONE = 1'b0;
        @(negedge CLK);
        check("idle_after_done", STATE_MON, 0);
        @(posedge CLK); #1;

        for (int k = 0; k < NV; k++) begin
            PERIOD_PAT = vecs[k].pat;
            PERIOD_PMT = vecs[k].pmt;
            PERIOD_SDT = vecs[k].sdt;
            T2MI_READY = vecs[k].t2mi;
            tick_n(vecs[k].ticks);
            do_slot(vecs[k].sel, lat);
            check($sformatf("vec%0d_latency", k), lat, 3);
            check($sformatf("vec%0d_overrun", k), {29'd0, OVERRUN}, {29'd0, vecs[k].ovr});
        end

        // PAT expires on the same edge its pending flag is cleared by a grant.
        PERIOD_PAT = 8'd1;
        T2MI_READY = 1'b1;
        tick_n(1);
        exp_q.push_back(3'd1);
        SLOT_REQ = 1'b1;
        @(posedge CLK); #1;
        TICK = 1'b1;
        @(posedge CLK); #1;
        TICK = 1'b0;
        PERIOD_PAT = 8'd0;
        wait_valid(lat);
        check("race_latency", lat, 1);
        end_slot();
        check("race_overrun", OVERRUN, 3'b110);
        do_slot(3'd0, lat);
        do_slot(3'd1, lat);
        check("race_overrun_after", OVERRUN, 3'b110);

        // Reset in BUSY with PAT pending abandons the slot and the pending flag.
        PERIOD_PAT = 8'd1;
        T2MI_READY = 1'b0;
        tick_n(1);
        exp_q.push_back(3'd1);
        SLOT_REQ = 1'b1;
        wait_valid(lat);
        @(posedge CLK); #1;
        SLOT_REQ = 1'b0;
        TICK = 1'b1;
        @(posedge CLK); #1;
        TICK = 1'b0;
        PERIOD_PAT = 8'd0;
        @(negedge CLK);
        check("busy_before_reset", STATE_MON, 2);
        @(posedge CLK); #1;
        RST = 1'b0;
        #2;
        check("midrst_sel",       SEL,       0);
        check("midrst_sel_valid", SEL_VALID, 0);
        check("midrst_overrun",   OVERRUN,   0);
        check("midrst_state",     STATE_MON, 0);
        @(posedge CLK);
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
`ifdef TS_NULL_PKT_EN
        do_slot(3'd4, lat);
        check("post_rst_null_latency", lat, 3);
        PERIOD_PAT = 8'd1;
        tick_n(1);
        PERIOD_PAT = 8'd0;
        do_slot(3'd1, lat);
`else
        SLOT_REQ = 1'b1;
        repeat (8) @(negedge CLK);
        check("post_rst_no_grant", STATE_MON, 1);
        @(posedge CLK); #1;
        PERIOD_PAT = 8'd1;
        exp_q.push_back(3'd1);
        tick_n(1);
        PERIOD_PAT = 8'd0;
        wait_valid(lat);
        end_slot();
`endif
        check("post_rst_overrun", OVERRUN, 0);

        repeat (3) @(posedge CLK);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
